pe_wbuf: RTL and testbench
==========================

// Module: pe_wbuf
// PURPOSE
//  Parametrised signed MAC processing element for the systolic array; next generation of the 8-bit PE.
//  Adds a double-buffered (shadow/active) weight, a selectable integer/fixed-point mode and a saturating accumulator.
//  Adds a configurable multiply pipeline, a stall input and a sticky overflow flag.
//  Tiled in the systolic array: value/valid pass east, partial sums pass south.
// PARAMETERS
//  DATA_W  8   width of the signed value and weight
//  SUM_W   16  width of the signed cumulative input and sum_out; must be >= DATA_W+1
//  FRAC_W  4   fraction bits used in fixed mode; must be < DATA_W
//  PIPE    1   multiply-accumulate latency in cycles; legal values 1 or 2
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous active-high reset
//  stall        in   1       hold the data pipeline
//  weight_load  in   1       write in_weight into the shadow register
//  in_weight    in   DATA_W  signed weight
//  weight_swap  in   1       copy shadow weight to active weight
//  in_valid     in   1       in_value and cumulative are valid
//  in_value     in   DATA_W  signed activation
//  cumulative   in   SUM_W   signed partial sum from the north PE
//  fixed_mode   in   1       0 = integer product; 1 = product >>> FRAC_W
//  ovf_clr      in   1       clear ovf_sticky
//  pass_value   out  DATA_W  registered in_value, to the east PE
//  pass_valid   out  1       registered in_valid
//  sum_out      out  SUM_W   saturated result, to the south PE
//  out_valid    out  1       sum_out is valid
//  overflow     out  1       sum_out for this result was saturated
//  ovf_sticky   out  1       set by any saturation; held until cleared
//  wstate       out  2       weight FSM state
// BEHAVIOUR
//  Reset (synchronous, rst=1 at a rising edge):
//   - every output is 0; the active and shadow weights are 0; wstate = W_EMPTY.
//   - rst has priority over all other inputs; a reset mid-operation discards all in-flight results.
//  Weight FSM, W_EMPTY(0) / W_READY(1) / W_ACTIVE(2):
//   - weight_load: shadow <= in_weight; EMPTY->READY, ACTIVE->READY, READY stays READY.
//   - weight_swap while READY: active <= shadow; -> ACTIVE.
//   - weight_swap while EMPTY or ACTIVE: ignored, no state change.
//   - load and swap in the same cycle: active <= old shadow, shadow <= in_weight, state stays READY.
//   - Weight updates and FSM transitions proceed regardless of stall.
//  Weight binding:
//   - An input beat uses the active-weight value present in its own entry cycle.
//   - A swap is visible only to beats entering after the swap edge.
//  Datapath, evaluated when stall=0:
//   - p = in_value * active (signed, 2*DATA_W bits).
//   - When fixed_mode=1, p = p >>> FRAC_W (arithmetic shift, truncates toward -inf); fixed_mode is sampled with the beat.
//   - s = sign-extended cumulative + sign-extended p, computed at SUM_W+2 bits.
//   - s is clamped to [-2^(SUM_W-1), 2^(SUM_W-1)-1]; overflow = 1 when clamping occurred.
//  Latency, counted in unstalled cycles:
//   - pass_value and pass_valid: 1 cycle.
//   - sum_out, out_valid and overflow: PIPE cycles.
//   - PIPE=2 registers p between the multiply and the add; cumulative is delayed 1 cycle so it stays aligned.
//  Result hold:
//   - sum_out holds its last value when no valid beat arrives.
//   - out_valid and overflow are 0 on cycles that carry no valid result.
//  Stall:
//   - stall=1 freezes every data-pipeline register and all outputs except wstate and ovf_sticky.
//   - Inputs presented during stall are ignored; no beat is lost or duplicated across a stall.
//  Sticky overflow:
//   - ovf_sticky is set on any cycle where out_valid & overflow is registered.
//   - ovf_clr clears it; if set and clear coincide, set wins.
// STRUCTURE
//  Package pe_pkg:
//   - wstate_e enum {W_EMPTY, W_READY, W_ACTIVE};
//   - function sat_add(cumulative, product) returning {overflow, sum}.
//  Sub-module pe_mac_pipe, parametrised on DATA_W/SUM_W/FRAC_W/PIPE:
//   - multiply, shift, saturating add and stage registers.
//  pe_wbuf owns the weight FSM, the pass-through registers and ovf_sticky.
// TESTING (DATA_W=8, SUM_W=16, FRAC_W=4; run PIPE=1 and PIPE=2)
//  1. Reset: drive rst=1 mid-stream with valid beats in flight.
//     -> all outputs 0 the next cycle and wstate=0; no out_valid until new input arrives.
//  2. Integer MAC: load 3, swap, then value=-5, cumulative=100, fixed_mode=0.
//     -> sum_out=85, out_valid=1 after PIPE cycles; pass_value=-5 after 1 cycle.
//  3. Fixed mode: active weight 0x20 (2.0), value 0x18 (1.5), cumulative 0.
//     -> sum_out=48 (0x30, i.e. 3.0 with 4 fraction bits).
//  4. Saturation: weight 127, value 127, cumulative 32767.
//     -> sum_out=32767, overflow=1, ovf_sticky=1.
//     ovf_clr together with a new overflow -> ovf_sticky stays 1.
//  5. Double buffer: active=2, load 7 while streaming value=1; swap on cycle k.
//     -> beats entering before the swap edge give 2, beats after give 7.
//     Swap while EMPTY -> ignored; load+swap in one cycle -> state READY.
//  6. Stall: 4 consecutive beats with stall=1 for 3 cycles in the middle.
//     -> exactly 4 results in order with correct sums; outputs frozen during stall.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg
//   Shared types and helpers for the pe_wbuf processing element.
//   wstate_e  : state of the shadow/active weight double buffer
//   sat_res_t : clamped sum plus overflow flag returned by sat_add
//   sat_add() : signed add, clamped to a sumW-bit two's complement range
package pe_pkg;

  typedef enum logic [1:0] {
    W_EMPTY  = 2'd0,
    W_READY  = 2'd1,
    W_ACTIVE = 2'd2
  } wstate_e;

  // The add is done wide enough that cumulative + product can never wrap
  // for any legal SUM_W/DATA_W, so the clamp decision is exact.
  localparam int SAT_CALC_W = 64;
  localparam logic signed [SAT_CALC_W-1:0] SAT_ONE = 1;

  // The sum sits above the flag, so a caller can narrow the whole result
  // with one size cast: bit 0 is the overflow flag, bits [sumW:1] the sum.
  typedef struct packed {
    logic signed [SAT_CALC_W-1:0] sum;
    logic                         ovf;
  } sat_res_t;

  function automatic sat_res_t sat_add(
    input logic signed [SAT_CALC_W-1:0] cumulative,
    input logic signed [SAT_CALC_W-1:0] product,
    input int                           sumW
  );
    logic signed [SAT_CALC_W-1:0] total;
    logic signed [SAT_CALC_W-1:0] maxV;
    logic signed [SAT_CALC_W-1:0] minV;
    sat_res_t                     res;
    total   = cumulative + product;
    maxV    = (SAT_ONE <<< (sumW - 1)) - SAT_ONE;
    minV    = -(SAT_ONE <<< (sumW - 1));
    res.sum = total;
    res.ovf = 1'b0;
    if (total > maxV) begin
      res.sum = maxV;
      res.ovf = 1'b1;
    end else if (total < minV) begin
      res.sum = minV;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_mac_pipe.sv
// pe_mac_pipe
//   Multiply / optional fixed-point shift / saturating accumulate datapath
//   of the processing element, with PIPE (1 or 2) cycles of latency.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   i_stall        : freeze every stage register and output
//   i_valid        : beat on i_value / i_cumulative is valid
//   i_value        : signed activation
//   i_weight       : signed active weight bound to this beat
//   i_cumulative   : signed partial sum from the north
//   i_fixedMode    : shift the product right by FRAC_W (arithmetic)
//   o_sum          : saturated result, held when no valid beat completes
//   o_valid        : o_sum carries a new result this cycle
//   o_overflow     : this result was clamped
//   o_ovfEvent     : a clamped result is being registered at the next edge
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int FRAC_W = 4,
  parameter int PIPE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_value,
  input  logic [DATA_W-1:0] i_weight,
  input  logic [SUM_W-1:0]  i_cumulative,
  input  logic              i_fixedMode,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_valid,
  output logic              o_overflow,
  output logic              o_ovfEvent
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] w_prodFull;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_addProd;
  logic [SUM_W-1:0]         w_addCum;
  logic                     w_addValid;
  logic [SUM_W:0]           w_sat;

  // Operands are sign-extended to the full product width first so the
  // multiply is a plain signed PROD_W x PROD_W with an exact low half.
  always_comb begin
    w_prodFull = $signed({{DATA_W{i_value[DATA_W-1]}}, i_value})
               * $signed({{DATA_W{i_weight[DATA_W-1]}}, i_weight});
    w_prod     = i_fixedMode ? (w_prodFull >>> FRAC_W) : w_prodFull;
  end

  // PIPE=2 registers the (already shifted) product and delays cumulative
  // and valid alongside it; any other PIPE value builds the 1-cycle path.
  if (PIPE == 2) begin : g_pipe2
    logic signed [PROD_W-1:0] r_prod;
    logic [SUM_W-1:0]         r_cum;
    logic                     r_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_prod  <= '0;
        r_cum   <= '0;
        r_valid <= 1'b0;
      end else if (!i_stall) begin
        r_prod  <= w_prod;
        r_cum   <= i_cumulative;
        r_valid <= i_valid;
      end
    end

    assign w_addProd  = r_prod;
    assign w_addCum   = r_cum;
    assign w_addValid = r_valid;
  end else begin : g_pipe1
    assign w_addProd  = w_prod;
    assign w_addCum   = i_cumulative;
    assign w_addValid = i_valid;
  end

  always_comb begin
    w_sat = (SUM_W + 1)'(sat_add(
              {{(SAT_CALC_W - SUM_W){w_addCum[SUM_W-1]}}, w_addCum},
              {{(SAT_CALC_W - PROD_W){w_addProd[PROD_W-1]}}, w_addProd},
              SUM_W));
  end

  // Output stage: the sum only moves on a valid beat, the flags are
  // rewritten every unstalled cycle so they drop on empty cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sum      <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (!i_stall) begin
      o_valid    <= w_addValid;
      o_overflow <= w_addValid & w_sat[0];
      if (w_addValid) begin
        o_sum <= w_sat[SUM_W:1];
      end
    end
  end

  assign o_ovfEvent = !i_stall & w_addValid & w_sat[0];

endmodule

// File: rtl/pe_wbuf.sv
// pe_wbuf
//   Signed MAC processing element for the systolic array with a
//   double-buffered weight, integer/fixed-point mode, saturating
//   accumulate, PIPE-cycle multiply latency, stall and sticky overflow.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hold the data pipeline (weights keep updating)
//   weight_load         : write in_weight into the shadow weight
//   in_weight           : signed weight
//   weight_swap         : copy shadow weight into the active weight
//   in_valid            : in_value / cumulative carry a beat
//   in_value            : signed activation
//   cumulative          : signed partial sum from the north PE
//   fixed_mode          : 1 = product >>> FRAC_W
//   ovf_clr             : clear ovf_sticky
//   pass_value/valid    : in_value / in_valid delayed 1 cycle, to the east
//   sum_out/out_valid   : saturated result after PIPE cycles, to the south
//   overflow            : sum_out for this result was clamped
//   ovf_sticky          : any clamped result since the last clear
//   wstate              : weight FSM state (wstate_e encoding)
module pe_wbuf
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int FRAC_W = 4,
  parameter int PIPE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              weight_load,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              weight_swap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_value,
  input  logic [SUM_W-1:0]  cumulative,
  input  logic              fixed_mode,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] pass_value,
  output logic              pass_valid,
  output logic [SUM_W-1:0]  sum_out,
  output logic              out_valid,
  output logic              overflow,
  output logic              ovf_sticky,
  output logic [1:0]        wstate
);

  wstate_e           r_wstate;
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_active;
  logic              w_ovfEvent;

  // Weight double buffer. A beat sampled at the swap edge still sees the
  // old active weight; load+swap together moves the old shadow to active
  // and leaves the new weight waiting in the shadow (state stays READY).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_EMPTY;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (weight_load) begin
        r_shadow <= in_weight;
      end
      case (r_wstate)
        W_EMPTY: begin
          if (weight_load) r_wstate <= W_READY;
        end
        W_READY: begin
          if (weight_swap) begin
            r_active <= r_shadow;
            if (!weight_load) r_wstate <= W_ACTIVE;
          end
        end
        W_ACTIVE: begin
          if (weight_load) r_wstate <= W_READY;
        end
        default: r_wstate <= W_EMPTY;
      endcase
    end
  end

  assign wstate = r_wstate;

  // East-going pass-through, frozen with the rest of the data pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_value <= '0;
      pass_valid <= 1'b0;
    end else if (!stall) begin
      pass_value <= in_value;
      pass_valid <= in_valid;
    end
  end

  // Set has priority over clear so a saturation is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (w_ovfEvent) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  pe_mac_pipe #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W),
    .FRAC_W (FRAC_W),
    .PIPE   (PIPE)
  ) u_mac (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (stall),
    .i_valid      (in_valid),
    .i_value      (in_value),
    .i_weight     (r_active),
    .i_cumulative (cumulative),
    .i_fixedMode  (fixed_mode),
    .o_sum        (sum_out),
    .o_valid      (out_valid),
    .o_overflow   (overflow),
    .o_ovfEvent   (w_ovfEvent)
  );

endmodule

// File: tb/tb_pe_wbuf.sv
`timescale 1ns/1ps
module tb_pe_wbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        weight_load;
  logic        weight_swap;
  logic        in_valid;
  logic        fixed_mode;
  logic        ovf_clr;
  logic [7:0]  in_weight;
  logic [7:0]  in_value;
  logic [15:0] cumulative;

  // Index 0 is the PIPE=1 instance, index 1 the PIPE=2 instance.
  wire [7:0]  passValue [2];
  wire        passValid [2];
  wire [15:0] sumOut    [2];
  wire        outValid  [2];
  wire        overflow  [2];
  wire        ovfSticky [2];
  wire [1:0]  wState    [2];

  int nChecks = 0;
  int nFails  = 0;

  logic        capEn     = 1'b0;
  logic        lastStall = 1'b0;
  logic [15:0] resQ0[$];
  logic [15:0] resQ1[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pe_wbuf #(
      .DATA_W (8),
      .SUM_W  (16),
      .FRAC_W (4),
      .PIPE   (g + 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .weight_load (weight_load),
      .in_weight   (in_weight),
      .weight_swap (weight_swap),
      .in_valid    (in_valid),
      .in_value    (in_value),
      .cumulative  (cumulative),
      .fixed_mode  (fixed_mode),
      .ovf_clr     (ovf_clr),
      .pass_value  (passValue[g]),
      .pass_valid  (passValid[g]),
      .sum_out     (sumOut[g]),
      .out_valid   (outValid[g]),
      .overflow    (overflow[g]),
      .ovf_sticky  (ovfSticky[g]),
      .wstate      (wState[g])
    );
  end

  // Remember whether the last edge was stalled, so a frozen result is
  // not logged twice.
  always @(posedge clk) lastStall <= stall;

  always @(negedge clk) begin
    if (capEn && !lastStall) begin
      if (outValid[0]) resQ0.push_back(sumOut[0]);
      if (outValid[1]) resQ1.push_back(sumOut[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    stall       = 1'b0;
    weight_load = 1'b0;
    weight_swap = 1'b0;
    in_valid    = 1'b0;
    fixed_mode  = 1'b0;
    ovf_clr     = 1'b0;
    in_weight   = '0;
    in_value    = '0;
    cumulative  = '0;
  endtask

  task automatic loadWeight(input logic [7:0] w);
    weight_load = 1'b1;
    in_weight   = w;
    tick();
    weight_load = 1'b0;
  endtask

  task automatic swapWeight();
    weight_swap = 1'b1;
    tick();
    weight_swap = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if ({passValue[k], passValid[k], sumOut[k], outValid[k], overflow[k],
           ovfSticky[k], wState[k]} !== 31'd0) begin
        nFails++;
        $display("[TB] FAIL reset_state pipe%0d: pv=%h pvld=%b sum=%h vld=%b ovf=%b sticky=%b ws=%0d, expected all 0",
                 k + 1, passValue[k], passValid[k], sumOut[k], outValid[k],
                 overflow[k], ovfSticky[k], wState[k]);
      end
    end
    rst = 1'b0;
    swapWeight();
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (wState[k] !== 2'd0) begin
        nFails++;
        $display("[TB] FAIL swap_empty pipe%0d: wstate=%0d, expected 0", k + 1, wState[k]);
      end
    end
  endtask

  task automatic test_integer_mac();
    logic [7:0]  wv [3];
    logic [7:0]  xv [3];
    logic [15:0] cv [3];
    logic [15:0] ev [3];
    $display("[TB] test_integer_mac");
    // 3*-5+100=85 ; -7*9-20=-83 ; 0*77+0x1234=0x1234
    wv = '{8'd3,    8'hF9,    8'd0};
    xv = '{8'hFB,   8'd9,     8'd77};
    cv = '{16'd100, 16'hFFEC, 16'h1234};
    ev = '{16'd85,  16'hFFAD, 16'h1234};
    for (int i = 0; i < 3; i++) begin
      loadWeight(wv[i]);
      swapWeight();
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (wState[k] !== 2'd2) begin
          nFails++;
          $display("[TB] FAIL int_wstate pipe%0d: wstate=%0d, expected 2", k + 1, wState[k]);
        end
      end
      in_valid   = 1'b1;
      in_value   = xv[i];
      cumulative = cv[i];
      fixed_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (passValue[k] !== xv[i] || passValid[k] !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL int_pass pipe%0d vec%0d: pv=%h pvld=%b, expected %h 1",
                   k + 1, i, passValue[k], passValid[k], xv[i]);
        end
      end
      for (int c = 1; c <= 2; c++) begin
        if (c == 2) tick();
        for (int k = 0; k < 2; k++) begin
          nChecks++;
          if (c == k + 1) begin
            if (outValid[k] !== 1'b1 || sumOut[k] !== ev[i] || overflow[k] !== 1'b0) begin
              nFails++;
              $display("[TB] FAIL int_sum pipe%0d vec%0d: sum=%0d vld=%b ovf=%b, expected %0d 1 0",
                       k + 1, i, $signed(sumOut[k]), outValid[k], overflow[k], $signed(ev[i]));
            end
          end else if (outValid[k] !== 1'b0 || (c > k + 1 && sumOut[k] !== ev[i])) begin
            nFails++;
            $display("[TB] FAIL int_idle pipe%0d vec%0d cyc%0d: vld=%b sum=%0d, expected vld 0 (held sum %0d)",
                     k + 1, i, c, outValid[k], $signed(sumOut[k]), $signed(ev[i]));
          end
        end
      end
    end
  endtask

  task automatic test_fixed_mode();
    logic [7:0]  wv [4];
    logic [7:0]  xv [4];
    logic [15:0] cv [4];
    logic [15:0] ev [4];
    $display("[TB] test_fixed_mode");
    // 2.0*1.5=3.0 -> 48 ; -1>>>4=-1 -> 9 ; 15>>>4=0 -> 10 ; -768>>>4=-48
    wv = '{8'h20,   8'h01,   8'h01,   8'h20};
    xv = '{8'h18,   8'hFF,   8'h0F,   8'hE8};
    cv = '{16'd0,   16'd10,  16'd10,  16'd0};
    ev = '{16'h0030, 16'd9,  16'd10,  16'hFFD0};
    for (int i = 0; i < 4; i++) begin
      loadWeight(wv[i]);
      swapWeight();
      in_valid   = 1'b1;
      in_value   = xv[i];
      cumulative = cv[i];
      fixed_mode = 1'b1;
      tick();
      in_valid   = 1'b0;
      fixed_mode = 1'b0;
      for (int c = 1; c <= 2; c++) begin
        if (c == 2) tick();
        for (int k = 0; k < 2; k++) begin
          if (c == k + 1) begin
            nChecks++;
            if (outValid[k] !== 1'b1 || sumOut[k] !== ev[i]) begin
              nFails++;
              $display("[TB] FAIL fixed_sum pipe%0d vec%0d: sum=%0d vld=%b, expected %0d 1",
                       k + 1, i, $signed(sumOut[k]), outValid[k], $signed(ev[i]));
            end
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0]  xv [2];
    logic [15:0] cv [2];
    $display("[TB] test_saturation");
    // 127*127+32767 clamps to 0x7FFF ; -128*127-32768 clamps to 0x8000
    xv = '{8'd127,   8'h80};
    cv = '{16'h7FFF, 16'h8000};
    loadWeight(8'd127);
    swapWeight();
    for (int i = 0; i < 2; i++) begin
      in_valid   = 1'b1;
      in_value   = xv[i];
      cumulative = cv[i];
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        if (c > 1) tick();
        for (int k = 0; k < 2; k++) begin
          nChecks++;
          if (c == k + 1) begin
            if (outValid[k] !== 1'b1 || sumOut[k] !== cv[i] || overflow[k] !== 1'b1 ||
                ovfSticky[k] !== 1'b1) begin
              nFails++;
              $display("[TB] FAIL sat_result pipe%0d vec%0d: sum=%h vld=%b ovf=%b sticky=%b, expected %h 1 1 1",
                       k + 1, i, sumOut[k], outValid[k], overflow[k], ovfSticky[k], cv[i]);
            end
          end else if (overflow[k] !== 1'b0 || (c > k + 1 && ovfSticky[k] !== 1'b1)) begin
            nFails++;
            $display("[TB] FAIL sat_idle pipe%0d vec%0d cyc%0d: ovf=%b sticky=%b, expected ovf 0",
                     k + 1, i, c, overflow[k], ovfSticky[k]);
          end
        end
      end
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ovfSticky[k] !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL sticky_clear pipe%0d: sticky=%b, expected 0", k + 1, ovfSticky[k]);
      end
    end
    // Two overflowing beats with clear held across both edges: each
    // instance sees a set and a clear together at least once.
    in_valid   = 1'b1;
    in_value   = 8'd127;
    cumulative = 16'h7FFF;
    ovf_clr    = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ovfSticky[k] !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL sticky_set_wins pipe%0d: sticky=%b, expected 1", k + 1, ovfSticky[k]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_double_buffer();
    logic [15:0] ev [7];
    $display("[TB] test_double_buffer");
    ev = '{16'd2, 16'd2, 16'd2, 16'd7, 16'd7, 16'd4, 16'd9};
    resQ0.delete();
    resQ1.delete();
    loadWeight(8'd2);
    swapWeight();
    capEn      = 1'b1;
    in_value   = 8'd1;
    cumulative = 16'd0;
    in_valid   = 1'b1;
    weight_load = 1'b1;
    in_weight   = 8'd7;
    tick();
    weight_load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (wState[k] !== 2'd1) begin
        nFails++;
        $display("[TB] FAIL db_ready pipe%0d: wstate=%0d, expected 1", k + 1, wState[k]);
      end
    end
    tick();
    // Beat entering at the swap edge still uses the old weight.
    weight_swap = 1'b1;
    tick();
    weight_swap = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    // Load+swap in one cycle: old shadow (4) goes active, 9 waits.
    loadWeight(8'd4);
    weight_load = 1'b1;
    in_weight   = 8'd9;
    weight_swap = 1'b1;
    tick();
    weight_load = 1'b0;
    weight_swap = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (wState[k] !== 2'd1) begin
        nFails++;
        $display("[TB] FAIL load_swap_state pipe%0d: wstate=%0d, expected 1", k + 1, wState[k]);
      end
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    swapWeight();
    swapWeight();
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (wState[k] !== 2'd2) begin
        nFails++;
        $display("[TB] FAIL swap_active_ignored pipe%0d: wstate=%0d, expected 2", k + 1, wState[k]);
      end
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    capEn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if ((k == 0 ? resQ0.size() : resQ1.size()) != 7) begin
        nFails++;
        $display("[TB] FAIL db_count pipe%0d: results=%0d, expected 7", k + 1,
                 (k == 0 ? resQ0.size() : resQ1.size()));
      end
    end
    for (int i = 0; i < 7; i++) begin
      nChecks++;
      if (i >= resQ0.size() || i >= resQ1.size() || resQ0[i] !== ev[i] || resQ1[i] !== ev[i]) begin
        nFails++;
        $display("[TB] FAIL db_result%0d: pipe1=%0d pipe2=%0d, expected %0d", i,
                 (i < resQ0.size() ? resQ0[i] : 16'hXXXX),
                 (i < resQ1.size() ? resQ1[i] : 16'hXXXX), ev[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] ev  [4];
    logic [15:0] frz [2];
    $display("[TB] test_stall");
    ev  = '{16'd13, 16'd26, 16'd39, 16'd52};
    frz = '{16'd26, 16'd13};
    resQ0.delete();
    resQ1.delete();
    loadWeight(8'd3);
    swapWeight();
    capEn = 1'b1;
    for (int b = 0; b < 2; b++) begin
      in_valid   = 1'b1;
      in_value   = 8'(b + 1);
      cumulative = 16'((b + 1) * 10);
      tick();
    end
    // Garbage on the data inputs while stalled must be ignored; a weight
    // load still goes through.
    stall       = 1'b1;
    in_value    = 8'd100;
    cumulative  = 16'd0;
    weight_load = 1'b1;
    in_weight   = 8'd5;
    for (int s = 0; s < 3; s++) begin
      tick();
      weight_load = 1'b0;
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (passValue[k] !== 8'd2 || passValid[k] !== 1'b1 || sumOut[k] !== frz[k] ||
            outValid[k] !== 1'b1 || overflow[k] !== 1'b0 || wState[k] !== 2'd1) begin
          nFails++;
          $display("[TB] FAIL stall_frozen pipe%0d cyc%0d: pv=%0d pvld=%b sum=%0d vld=%b ovf=%b ws=%0d, expected 2 1 %0d 1 0 1",
                   k + 1, s, passValue[k], passValid[k], sumOut[k], outValid[k],
                   overflow[k], wState[k], frz[k]);
        end
      end
    end
    stall = 1'b0;
    for (int b = 2; b < 4; b++) begin
      in_valid   = 1'b1;
      in_value   = 8'(b + 1);
      cumulative = 16'((b + 1) * 10);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    capEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (i >= resQ0.size() || i >= resQ1.size() || resQ0[i] !== ev[i] || resQ1[i] !== ev[i]) begin
        nFails++;
        $display("[TB] FAIL stall_result%0d: pipe1=%0d pipe2=%0d, expected %0d", i,
                 (i < resQ0.size() ? resQ0[i] : 16'hXXXX),
                 (i < resQ1.size() ? resQ1[i] : 16'hXXXX), ev[i]);
      end
    end
    nChecks++;
    if (resQ0.size() != 4 || resQ1.size() != 4) begin
      nFails++;
      $display("[TB] FAIL stall_count: pipe1=%0d pipe2=%0d, expected 4 4", resQ0.size(), resQ1.size());
    end
  endtask

  task automatic test_reset_midstream();
    $display("[TB] test_reset_midstream");
    in_valid   = 1'b1;
    in_value   = 8'd1;
    cumulative = 16'd0;
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if ({passValue[k], passValid[k], sumOut[k], outValid[k], overflow[k],
           ovfSticky[k], wState[k]} !== 31'd0) begin
        nFails++;
        $display("[TB] FAIL reset_mid pipe%0d: pv=%h pvld=%b sum=%h vld=%b ovf=%b sticky=%b ws=%0d, expected all 0",
                 k + 1, passValue[k], passValid[k], sumOut[k], outValid[k],
                 overflow[k], ovfSticky[k], wState[k]);
      end
    end
    rst = 1'b0;
    idleInputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        nChecks++;
        if (outValid[k] !== 1'b0 || sumOut[k] !== 16'd0) begin
          nFails++;
          $display("[TB] FAIL reset_flush pipe%0d cyc%0d: vld=%b sum=%0d, expected 0 0",
                   k + 1, c, outValid[k], sumOut[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_integer_mac();
    test_fixed_mode();
    test_saturation();
    test_double_buffer();
    test_stall();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
